// File: rtl/bus_gnrtr_pkg.sv
// Shared types and helpers for the bus generator / arbiter.
// Holds the destination-ID width rule, the broadcast code, the per-bus
// FSM state encoding and the packet destination-field extractor.
package bus_gnrtr_pkg;

    // Widest packet the field-extract helper handles.
    localparam int PKT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    // Destination-ID width: enough codes for every driver plus broadcast.
    function automatic int id_w(input int n_drvrs);
        return $clog2(n_drvrs + 1);
    endfunction

    // Broadcast code is the all-ones ID of the given width.
    function automatic logic [31:0] bcast_id(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Destination field lives in the top w bits of a pkt_w-bit packet.
    function automatic logic [PKT_MAX_W-1:0] pkt_dest(
        input logic [PKT_MAX_W-1:0] pkt,
        input int                   pkt_w,
        input int                   w
    );
        logic [PKT_MAX_W-1:0] mask;
        mask = (PKT_MAX_W'(1) << w) - PKT_MAX_W'(1);
        return (pkt >> (pkt_w - w)) & mask;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// One bus worth of arbitration: round-robin pick of a pending driver,
// pop its head packet, then push it to the destination lane(s).
// Optional macro BCAST_LOOPBACK_EN: broadcast also returns to the source.
module bus_rr_arbiter
    import bus_gnrtr_pkg::*;
#(
    parameter int DRVRS = 4,
    parameter int PKT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DRVRS-1:0]             pndng_i,
    input  logic [DRVRS-1:0][PKT_W-1:0]  d_pop_i,
    output logic [DRVRS-1:0]             pop_o,
    output logic [DRVRS-1:0]             push_o,
    output logic [DRVRS-1:0][PKT_W-1:0]  d_push_o
);

    localparam int                PW    = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int                ID_W  = id_w(DRVRS);
    localparam logic [ID_W-1:0]   BCAST = ID_W'(bcast_id(ID_W));

    if (PKT_W < ID_W) begin : g_bad_cfg
        $error("bus_rr_arbiter: packet narrower than destination ID field");
    end

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q,   ptr_d;
    logic [PW-1:0]       src_q,   src_d;
    logic [DRVRS-1:0]    pop_q,   pop_d;
    logic [DRVRS-1:0]    push_q,  push_d;
    logic [PKT_W-1:0]    pkt_q,   pkt_d;

    logic                sel_found;
    logic [PW-1:0]       sel_idx;
    logic [PW-1:0]       cand;
    int                  k;
    logic [PKT_W-1:0]    pkt_in;
    logic [ID_W-1:0]     dest;

    // State, pointer, capture and registered strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            pkt_q   <= pkt_d;
        end
    end

    // Round-robin search: first pending index at or after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        k         = 0;
        for (int i = 0; i < DRVRS; i++) begin
            k = int'(ptr_q) + i;
            if (k >= DRVRS) k = k - DRVRS;
            cand = PW'(k);
            if (!sel_found && pndng_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Head packet of the granted source and its destination field.
    always_comb begin
        pkt_in = d_pop_i[src_q];
        dest   = ID_W'(pkt_dest(PKT_MAX_W'(pkt_in), PKT_W, ID_W));
    end

    // Next-state and strobe generation; strobes default low so each lasts one cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pop_d   = '0;
        push_d  = '0;
        pkt_d   = pkt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    src_d          = sel_idx;
                    pop_d[sel_idx] = 1'b1;
                    state_d        = POP;
                end
            end
            POP: begin
                // Capture happens regardless of pndng; the source owns that risk.
                pkt_d = pkt_in;
                if (dest == BCAST) begin
`ifdef BCAST_LOOPBACK_EN
                    push_d = '1;
`else
                    for (int i = 0; i < DRVRS; i++) begin
                        if (PW'(i) != src_q) push_d[i] = 1'b1;
                    end
`endif
                end else begin
                    // Unmatched IDs leave push_d clear: packet dropped.
                    for (int i = 0; i < DRVRS; i++) begin
                        if (ID_W'(i) == dest) push_d[i] = 1'b1;
                    end
                end
                state_d = PUSH;
            end
            PUSH: begin
                if (src_q == PW'(DRVRS - 1)) ptr_d = '0;
                else                         ptr_d = src_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_o    = pop_q;
    assign push_o   = push_q;
    assign d_push_o = {DRVRS{pkt_q}};

endmodule

// File: rtl/bus_gnrtr_n_arbiter.sv
// Shared-bus generator and arbiter: `bits` independent buses, each with
// its own round-robin arbiter between `drvrs` driver FIFOs.
// Optional macro BCAST_LOOPBACK_EN (handled in bus_rr_arbiter).
module bus_gnrtr_n_arbiter
    import bus_gnrtr_pkg::*;
#(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]             pop,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_rr_arbiter #(
            .DRVRS (drvrs),
            .PKT_W (pckg_sz)
        ) u_arb (
            .clk_i    (clk),
            .rst_i    (reset),
            .pndng_i  (pndng[b]),
            .d_pop_i  (D_pop[b]),
            .pop_o    (pop[b]),
            .push_o   (push[b]),
            .d_push_o (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_gnrtr_n_arbiter.sv
// Directed bench for bus_gnrtr_n_arbiter with one bus, 8 drivers, 4-bit packets.
module tb_bus_gnrtr_n_arbiter;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [0:0][7:0]       pndng = '0;
    logic [0:0][7:0][3:0]  d_pop = '0;
    logic [0:0][7:0]       pop;
    logic [0:0][7:0]       push;
    logic [0:0][7:0][3:0]  d_push;

    int errors = 0;
    int checks = 0;

    bus_gnrtr_n_arbiter #(.bits(1), .drvrs(8), .pckg_sz(4)) dut (
        .clk    (clk),
        .reset  (rst),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .push   (push),
        .D_push (d_push)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (pop[0] !== 8'h00) begin errors++; $display("FAIL reset_pop got=%h exp=00", pop[0]); end
        checks++; if (push[0] !== 8'h00) begin errors++; $display("FAIL reset_push got=%h exp=00", push[0]); end
        checks++; if (d_push[0] !== 32'h0) begin errors++; $display("FAIL reset_dpush got=%h exp=0", d_push[0]); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unicast();
        pndng[0][2] = 1'b1; d_pop[0][2] = 4'h5;
        tick();
        checks++; if (pop[0] !== 8'h04) begin errors++; $display("FAIL uni_pop got=%h exp=04", pop[0]); end
        checks++; if (push[0] !== 8'h00) begin errors++; $display("FAIL uni_push_early got=%h exp=00", push[0]); end
        pndng[0][2] = 1'b0;
        tick();
        checks++; if (push[0] !== 8'h20) begin errors++; $display("FAIL uni_push got=%h exp=20", push[0]); end
        checks++; if (pop[0] !== 8'h00) begin errors++; $display("FAIL uni_pop_one_cycle got=%h exp=00", pop[0]); end
        checks++; if (d_push[0] !== {8{4'h5}}) begin errors++; $display("FAIL uni_dpush got=%h exp=%h", d_push[0], {8{4'h5}}); end
        tick();
        checks++; if (push[0] !== 8'h00) begin errors++; $display("FAIL uni_push_one_cycle got=%h exp=00", push[0]); end
        checks++; if (d_push[0] !== {8{4'h5}}) begin errors++; $display("FAIL uni_dpush_hold got=%h exp=%h", d_push[0], {8{4'h5}}); end
    endtask

    // Pointer is 3 here; source 6 gets the grant, then reset hits during POP.
    task automatic test_reset_mid_pop();
        pndng[0][6] = 1'b1; d_pop[0][6] = 4'h1;
        tick();
        checks++; if (pop[0] !== 8'h40) begin errors++; $display("FAIL midrst_pop_before got=%h exp=40", pop[0]); end
        rst = 1'b1;
        #1;
        checks++; if (pop[0] !== 8'h00) begin errors++; $display("FAIL midrst_pop got=%h exp=00", pop[0]); end
        checks++; if (push[0] !== 8'h00) begin errors++; $display("FAIL midrst_push got=%h exp=00", push[0]); end
        checks++; if (d_push[0] !== 32'h0) begin errors++; $display("FAIL midrst_dpush got=%h exp=0", d_push[0]); end
        tick();
        rst = 1'b0;
        // Pointer back at 0 must pick 1 ahead of 6.
        pndng[0] = 8'h42; d_pop[0][1] = 4'h2; d_pop[0][6] = 4'h3;
        tick();
        checks++; if (pop[0] !== 8'h02) begin errors++; $display("FAIL midrst_ptr0_pop got=%h exp=02", pop[0]); end
        pndng[0] = 8'h00;
        tick();
        checks++; if (push[0] !== 8'h04) begin errors++; $display("FAIL midrst_ptr0_push got=%h exp=04", push[0]); end
        checks++; if (d_push[0] !== {8{4'h2}}) begin errors++; $display("FAIL midrst_dpush2 got=%h exp=%h", d_push[0], {8{4'h2}}); end
        tick();
    endtask

    task automatic test_broadcast();
        logic [7:0] exp_b;
`ifdef BCAST_LOOPBACK_EN
        exp_b = 8'hFF;
`else
        exp_b = 8'hF7;
`endif
        pndng[0][3] = 1'b1; d_pop[0][3] = 4'hF;
        tick();
        checks++; if (pop[0] !== 8'h08) begin errors++; $display("FAIL bcast_pop got=%h exp=08", pop[0]); end
        pndng[0][3] = 1'b0;
        tick();
        checks++; if (push[0] !== exp_b) begin errors++; $display("FAIL bcast_push got=%h exp=%h", push[0], exp_b); end
        checks++; if (d_push[0] !== {8{4'hF}}) begin errors++; $display("FAIL bcast_dpush got=%h exp=%h", d_push[0], {8{4'hF}}); end
        tick();
    endtask

    // Pointer is 4 here; source 5 sends invalid ID 9.
    task automatic test_invalid_id();
        pndng[0][5] = 1'b1; d_pop[0][5] = 4'h9;
        tick();
        checks++; if (pop[0] !== 8'h20) begin errors++; $display("FAIL inv_pop got=%h exp=20", pop[0]); end
        pndng[0][5] = 1'b0;
        tick();
        checks++; if (push[0] !== 8'h00) begin errors++; $display("FAIL inv_push got=%h exp=00", push[0]); end
        checks++; if (d_push[0] !== {8{4'h9}}) begin errors++; $display("FAIL inv_dpush got=%h exp=%h", d_push[0], {8{4'h9}}); end
        tick();
        // Pointer must now be 6: with 1 and 5 pending, 1 wins.
        pndng[0] = 8'h22; d_pop[0][1] = 4'h0; d_pop[0][5] = 4'h0;
        tick();
        checks++; if (pop[0] !== 8'h02) begin errors++; $display("FAIL inv_ptr_adv got=%h exp=02", pop[0]); end
        pndng[0] = 8'h00;
        tick();
        tick();
    endtask

    // Pointer is 2 here; driver 6 addresses itself.
    task automatic test_loopback();
        pndng[0][6] = 1'b1; d_pop[0][6] = 4'h6;
        tick();
        checks++; if (pop[0] !== 8'h40) begin errors++; $display("FAIL loop_pop got=%h exp=40", pop[0]); end
        pndng[0][6] = 1'b0;
        tick();
        checks++; if (push[0] !== 8'h40) begin errors++; $display("FAIL loop_push got=%h exp=40", push[0]); end
        tick();
    endtask

    // Drivers 0, 4, 7 pending continuously after a fresh reset.
    task automatic test_round_robin();
        logic [7:0] exp_pop, exp_push;
        int slot;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_pop[0][0] = 4'h1; d_pop[0][4] = 4'h2; d_pop[0][7] = 4'h3;
        pndng[0] = 8'h91;
        for (int c = 1; c <= 12; c++) begin
            tick();
            slot = ((c - 1) / 3) % 3;
            exp_pop  = 8'h00;
            exp_push = 8'h00;
            if (c % 3 == 1) begin
                case (slot)
                    0: exp_pop = 8'h01;
                    1: exp_pop = 8'h10;
                    default: exp_pop = 8'h80;
                endcase
            end
            if (c % 3 == 2) begin
                case (slot)
                    0: exp_push = 8'h02;
                    1: exp_push = 8'h04;
                    default: exp_push = 8'h08;
                endcase
            end
            checks++; if (pop[0] !== exp_pop) begin errors++; $display("FAIL rr_pop cyc=%0d got=%h exp=%h", c, pop[0], exp_pop); end
            checks++; if (push[0] !== exp_push) begin errors++; $display("FAIL rr_push cyc=%0d got=%h exp=%h", c, push[0], exp_push); end
        end
        pndng[0] = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_reset_mid_pop();
        test_broadcast();
        test_invalid_id();
        test_loopback();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
